// File: rtl/serial_paralelo.sv
// Serial-to-parallel receive stage: hunts for comma alignment, locks after
// COMMA_LOCK aligned commas, then presents one byte per 8 bit-clocks.
module serial_paralelo #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned COMMA_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    typedef enum logic [1:0] {
        ST_ALIGN  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(COMMA_LOCK);

    state_t     r_state, w_state_next;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [3:0] r_comma_cnt, w_comma_cnt_next;
    logic [7:0] r_data, w_data_next;
    logic       r_valid, w_valid_next;
    logic       r_active, w_active_next;
    logic       r_strobe, w_strobe_next;

    logic [7:0] w_window;
    logic       w_is_comma;
    logic       w_boundary;

    assign w_window   = {r_sr[6:0], data_in};
    assign w_is_comma = (w_window == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_comma_cnt_next = r_comma_cnt;
        w_data_next      = r_data;
        w_valid_next     = r_valid;
        w_active_next    = r_active;
        w_strobe_next    = 1'b0;
        case (r_state)
            ST_ALIGN: begin
                // Any bit position may start a byte; the first full comma sets the phase.
                if (w_is_comma) begin
                    w_bit_cnt_next   = 3'd0;
                    w_comma_cnt_next = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        w_state_next  = ST_ACTIVE;
                        w_active_next = 1'b1;
                    end else begin
                        w_state_next = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        if (r_comma_cnt + 4'd1 >= LOCK_CNT) begin
                            w_comma_cnt_next = LOCK_CNT;
                            w_state_next     = ST_ACTIVE;
                            w_active_next    = 1'b1;
                        end else begin
                            w_comma_cnt_next = r_comma_cnt + 4'd1;
                        end
                    end else begin
                        w_comma_cnt_next = 4'd0;
                        w_state_next     = ST_ALIGN;
                    end
                end
            end
            ST_ACTIVE: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_data_next   = w_window;
                    w_valid_next  = ~w_is_comma;
                    w_strobe_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ALIGN;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            r_state     <= ST_ALIGN;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_window;
            r_bit_cnt   <= w_bit_cnt_next;
            r_comma_cnt <= w_comma_cnt_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_active    <= w_active_next;
            r_strobe    <= w_strobe_next;
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign active      = r_active;
    assign byte_strobe = r_strobe;

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: every cycle the outputs are compared
// against a model that scans the whole bit history since reset for the lock point.
module tb_serial_paralelo;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         LOCK  = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic bits[$];

    serial_paralelo #(.COMMA(COMMA), .COMMA_LOCK(LOCK)) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active     (active),
        .byte_strobe(byte_strobe)
    );

    always #5 clk_32f = ~clk_32f;

    // Byte formed by the 8 bits ending at index i (zeros before reset release).
    function automatic logic [7:0] win(int i);
        logic [7:0] w;
        w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = i - 7 + k;
            w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
        end
        return w;
    endfunction

    // Index of the last bit of the LOCK-th aligned comma, or -1 if not locked yet.
    function automatic int lock_index();
        int n;
        int i;
        n = bits.size();
        i = 0;
        while (i < n) begin
            if (win(i) == COMMA) begin
                int k;
                int j;
                k = 1;
                j = i;
                while (k < LOCK) begin
                    j = j + 8;
                    if (j >= n) return -1;
                    if (win(j) != COMMA) break;
                    k++;
                end
                if (k == LOCK) return j;
                i = j + 1;
            end else begin
                i++;
            end
        end
        return -1;
    endfunction

    task automatic check_cycle();
        int         l;
        int         i;
        logic [7:0] exp_d;
        logic       exp_v;
        logic       exp_a;
        logic       exp_s;
        l     = lock_index();
        i     = bits.size() - 1;
        exp_d = 8'h00;
        exp_v = 1'b0;
        exp_a = (l >= 0) && (i >= l);
        exp_s = 1'b0;
        if (l >= 0 && i - l >= 8) begin
            int b;
            b     = l + 8 * ((i - l) / 8);
            exp_d = win(b);
            exp_v = (exp_d != COMMA);
            exp_s = ((i - l) % 8 == 0);
        end
        total_cnt++;
        assert (data_out === exp_d) pass_cnt++;
        else $error("FAIL data_out cyc=%0d got=%h exp=%h", cyc, data_out, exp_d);
        total_cnt++;
        assert (valid_out === exp_v) pass_cnt++;
        else $error("FAIL valid_out cyc=%0d got=%b exp=%b", cyc, valid_out, exp_v);
        total_cnt++;
        assert (active === exp_a) pass_cnt++;
        else $error("FAIL active cyc=%0d got=%b exp=%b", cyc, active, exp_a);
        total_cnt++;
        assert (byte_strobe === exp_s) pass_cnt++;
        else $error("FAIL byte_strobe cyc=%0d got=%b exp=%b", cyc, byte_strobe, exp_s);
        if (exp_s)
            $display("cyc=%0d byte=%h valid=%b", cyc, data_out, valid_out);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        cyc++;
        bits.push_back(b);
        check_cycle();
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int k = 7; k >= 0; k--) send_bit(x[k]);
    endtask

    task automatic reset_cycles(input int n);
        reset_L = 1'b0;
        for (int k = 0; k < n; k++) begin
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            cyc++;
            bits.delete();
            check_cycle();
        end
        reset_L = 1'b1;
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    endtask

    initial begin
        reset_L = 1'b0;
        data_in = 1'b0;

        // Reset held with random data.
        reset_cycles(4);

        // Lock after random prefix, then FF, DD and random payload.
        repeat (3) send_bit(1'($urandom));
        repeat (4) send_byte(COMMA);
        expect_bit("active_after_lock", active, 1'b1);
        send_byte(8'hFF);
        send_byte(8'hDD);
        repeat (3) send_byte(8'($urandom));

        // Broken lock, then relock.
        reset_cycles(1);
        repeat (3) send_byte(COMMA);
        send_byte(8'h55);
        expect_bit("active_broken", active, 1'b0);
        repeat (4) send_byte(COMMA);
        send_byte(8'h77);
        // Idle character inside ACTIVE.
        send_byte(8'hAA);
        send_byte(COMMA);
        send_byte(8'h88);

        // Misaligned comma prefix followed by aligned commas.
        reset_cycles(2);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        repeat (3) send_byte(COMMA);
        repeat (4) send_byte(8'($urandom));

        // Reset mid-byte while ACTIVE, then fresh lock.
        repeat (3) send_bit(1'($urandom));
        reset_cycles(1);
        expect_bit("active_after_reset", active, 1'b0);
        repeat (3) send_byte(COMMA);
        send_byte(8'h3C);
        repeat (4) send_byte(COMMA);
        repeat (4) send_byte(8'($urandom));
        repeat (8) send_bit(1'($urandom));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
